uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   Serial transmitter: accepts a parallel word over a valid/ready handshake and
//   shifts it out on a single line as an 8N1-style asynchronous frame.
//   Transmit end of the Sequential-library serial link; the matching receiver samples its line.
//   Built from registered flops with asynchronous reset only.
// PARAMETERS
//   CLKS_PER_BIT  16  clk cycles per serial bit; legal range >= 2
//   DATA_BITS     8   payload width, 5..9
//   PARITY_EN     0   1 = append parity bit after data
//   PARITY_ODD    0   1 = odd parity, 0 = even (only if PARITY_EN)
//   STOP_BITS     1   number of stop bits, 1 or 2
// PORTS
//   clk       in   1          rising-edge clock, single domain
//   rst       in   1          asynchronous, active-high reset
//   tx_data   in   DATA_BITS  word to send; sampled only on accept
//   tx_valid  in   1          source has a word; held until accepted
//   tx_ready  out  1          block can accept a word this cycle
//   tx        out  1          serial line, idle high
//   busy      out  1          frame in progress (start through last stop cycle)
// BEHAVIOUR
//   - Reset (async, immediate): tx=1, tx_ready=1, busy=0, state=IDLE, counters=0.
//     Reset mid-frame aborts the frame; tx goes high without waiting for clk.
//   - All outputs are registered; tx never glitches.
//   - Accept: tx_valid && tx_ready at a rising edge. tx_data is latched into the shift register.
//     On that edge: tx_ready->0, busy->1, and tx->0 (start bit begins next cycle; latency 1).
//   - tx_valid while tx_ready=0 is ignored. tx_data changes during a frame have no effect.
//   - Each bit holds tx for exactly CLKS_PER_BIT cycles. A baud counter counts 0..CLKS_PER_BIT-1.
//   - States and transitions:
//       IDLE -> START on accept.
//       START -> DATA after 1 bit time.
//       DATA: DATA_BITS bits, LSB first.
//         Then -> PARITY if PARITY_EN, else -> STOP.
//       PARITY: ^data (even), inverted for odd; 1 bit time -> STOP.
//       STOP: tx=1 for STOP_BITS bit times -> IDLE.
//   - Frame length F = (1+DATA_BITS+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
//     Default F = 160.
//   - On entering IDLE: tx_ready=1, busy=0.
//     If tx_valid is high in that first IDLE cycle, the next start bit follows immediately.
//     Minimum inter-frame gap is therefore 1 extra high cycle.
//   - bit_idx width = $clog2(DATA_BITS); baud width = $clog2(CLKS_PER_BIT).
//     Both counters wrap to 0 on each transition; no overflow is possible.
//   - Illegal parameter values stop elaboration via a generate-time $error.
// STRUCTURE
//   - uart_defs.vh: state encodings IDLE/START/DATA/PARITY/STOP (3-bit localparams)
//     and the frame-length helper. Shared with uart_rx.
//   - Sub-module uart_baud_counter:
//     inputs clk, rst, clr; output bit_done.
//     bit_done pulses on count CLKS_PER_BIT-1. clr is asserted on accept.
//   - uart_tx holds the FSM, shift register, bit_idx and parity accumulator.
// TESTING
//   1. rst=1 for 7 time units mid-idle, then released:
//      tx=1, tx_ready=1, busy=0, no activity on tx.
//   2. Send 8'hA5 with defaults:
//      tx = 0,1,0,1,0,0,1,0,1,1, each held 16 cycles.
//      busy is high for 160 cycles; tx_ready returns 1 afterwards.
//   3. Back-to-back: tx_valid held high with 8'h00 then 8'hFF:
//      second start bit begins 1 cycle after first stop ends; both frames decode correctly.
//   4. PARITY_EN=1, PARITY_ODD=0, data 8'h07:
//      parity bit = 1; with PARITY_ODD=1 parity bit = 0.
//      Frame length is 176 cycles.
//   5. Assert rst 3 cycles into bit 4 of 8'h3C:
//      tx goes high immediately (before next clk edge), tx_ready=1.
//      A new word sent after release is transmitted intact.
//   6. STOP_BITS=2, CLKS_PER_BIT=4:
//      stop high for 8 cycles; tx_valid toggling during the frame is ignored.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the serial transmitter: FSM state encoding and frame-length helper.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Total clk cycles from start-bit entry to the end of the last stop bit.
    function automatic int frame_cycles(input int clks_per_bit, input int data_bits,
                                        input int parity_en, input int stop_bits);
        return (1 + data_bits + parity_en + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_done
);

    localparam int                CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    assign bit_done = (r_count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr || bit_done) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Asynchronous serial transmitter: valid/ready word in, start/data/parity/stop frame out.
// Accept-to-start-bit latency is one cycle; tx_ready stays low for the whole frame.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int               IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
            STOP_BITS < 1 || STOP_BITS > 2 ||
            PARITY_EN < 0 || PARITY_EN > 1 ||
            PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
            $error("uart_tx: illegal parameter combination");
        end
    endgenerate

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 r_par;
    logic                 r_stop_cnt;
    logic                 w_accept;
    logic                 w_bit_done;

    assign w_accept = tx_valid && tx_ready;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_accept),
        .bit_done (w_bit_done)
    );

    // The line value for the next bit is loaded on the same edge that ends the current
    // bit, so tx is always a flop output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_par      <= 1'b0;
            r_stop_cnt <= 1'b0;
            tx         <= 1'b1;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift   <= tx_data;
                        r_par     <= (PARITY_ODD != 0);
                        r_bit_idx <= '0;
                        tx        <= 1'b0;
                        tx_ready  <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_done) begin
                        tx      <= r_shift[0];
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_par   <= r_par ^ r_shift[0];
                        r_shift <= r_shift >> 1;
                        if (r_bit_idx == LAST_IDX) begin
                            r_bit_idx  <= '0;
                            r_stop_cnt <= 1'b0;
                            if (PARITY_EN != 0) begin
                                tx      <= r_par ^ r_shift[0];
                                r_state <= S_PARITY;
                            end else begin
                                tx      <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            tx        <= r_shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_done) begin
                        tx      <= 1'b1;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_bit_done) begin
                        if (r_stop_cnt == LAST_STOP) begin
                            r_stop_cnt <= 1'b0;
                            tx_ready   <= 1'b1;
                            busy       <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    tx       <= 1'b1;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameterisations driven with directed and random words, each
// line cycle compared against a frame model built from the bit-level frame format.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data  [4];
    logic       tx_valid [4];
    logic       tx_ready [4];
    logic       tx_line  [4];
    logic       busy     [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx u_def (
        .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .tx(tx_line[0]), .busy(busy[0]));

    uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u_even (
        .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .tx(tx_line[1]), .busy(busy[1]));

    uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .tx(tx_line[2]), .busy(busy[2]));

    uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .rst(rst), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
        .tx_ready(tx_ready[3]), .tx(tx_line[3]), .busy(busy[3]));

    // Per-instance configuration, mirroring the parameter overrides above.
    function automatic int cpb_of(input int d);
        return (d == 3) ? 4 : 16;
    endfunction
    function automatic int pen_of(input int d);
        return (d == 1 || d == 2) ? 1 : 0;
    endfunction
    function automatic int podd_of(input int d);
        return (d == 2) ? 1 : 0;
    endfunction
    function automatic int nstop_of(input int d);
        return (d == 3) ? 2 : 1;
    endfunction
    function automatic int flen_of(input int d);
        return (1 + 8 + pen_of(d) + nstop_of(d)) * cpb_of(d);
    endfunction

    // Expected line level for frame bit position b (0 = start bit).
    function automatic logic model_bit(input int d, input logic [7:0] data, input int b);
        if (b == 0)                       return 1'b0;
        if (b <= 8)                       return data[b-1];
        if (pen_of(d) == 1 && b == 9)     return (^data) ^ (podd_of(d) == 1);
        return 1'b1;
    endfunction

    task automatic check(input string tag, input int d, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d: observed %b expected %b at %0t", tag, d, obs, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag, input int d);
        check({tag, "_tx"},    d, tx_line[d],  1'b1);
        check({tag, "_ready"}, d, tx_ready[d], 1'b1);
        check({tag, "_busy"},  d, busy[d],     1'b0);
    endtask

    task automatic start(input int d, input logic [7:0] data);
        @(negedge clk);
        tx_data[d]  = data;
        tx_valid[d] = 1'b1;
    endtask

    // mode 0: valid drops after accept; 1: valid held with next_data for a back-to-back
    // frame; 2: valid toggles randomly during the frame. abort_at >= 0 resets mid-frame.
    task automatic run_frame(input int d, input logic [7:0] data, input int mode,
                             input logic [7:0] next_data, input int abort_at);
        @(posedge clk);
        for (int k = 0; k < flen_of(d); k++) begin
            @(negedge clk);
            tx_valid[d] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(1)) : 1'b0;
            tx_data[d]  = (mode == 1) ? next_data : 8'($urandom);
            check("frame_tx",    d, tx_line[d],  model_bit(d, data, k / cpb_of(d)));
            check("frame_busy",  d, busy[d],     1'b1);
            check("frame_ready", d, tx_ready[d], 1'b0);
            if (k == abort_at) begin
                tx_valid[d] = 1'b0;
                #2 rst = 1'b1;
                #1 check_idle("abort_async", d);
                @(negedge clk);
                check_idle("abort_held", d);
                rst = 1'b0;
                return;
            end
        end
        @(negedge clk);
        check_idle("frame_end", d);
        tx_valid[d] = (mode == 1);
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin
            tx_data[d]  = 8'h00;
            tx_valid[d] = 1'b0;
        end
        rst = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) check_idle("reset", d);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Short reset pulse while idle: line must stay quiet.
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1 check_idle("pulse_rst", 0);
        #6 rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check_idle("idle_quiet", 0);
        end

        // Default frame with a known pattern.
        start(0, 8'hA5);
        run_frame(0, 8'hA5, 0, 8'h00, -1);

        // Back-to-back: valid held across the frame boundary.
        start(0, 8'h00);
        run_frame(0, 8'h00, 1, 8'hFF, -1);
        run_frame(0, 8'hFF, 0, 8'h00, -1);

        // Even and odd parity on the same word.
        start(1, 8'h07);
        run_frame(1, 8'h07, 0, 8'h00, -1);
        start(2, 8'h07);
        run_frame(2, 8'h07, 0, 8'h00, -1);

        // Reset three cycles into data bit 4, then a fresh word.
        start(0, 8'h3C);
        run_frame(0, 8'h3C, 0, 8'h00, 5 * 16 + 3);
        start(0, 8'h96);
        run_frame(0, 8'h96, 0, 8'h00, -1);

        // Two stop bits at 4 clocks per bit with tx_valid toggling mid-frame.
        start(3, 8'h5A);
        run_frame(3, 8'h5A, 2, 8'h00, -1);

        // Randomised words and handshake modes across all configurations.
        for (int r = 0; r < 3; r++) begin
            for (int d = 0; d < 4; d++) begin
                logic [7:0] a;
                logic [7:0] b;
                int         m;
                a = 8'($urandom);
                b = 8'($urandom);
                m = int'($urandom_range(2));
                start(d, a);
                run_frame(d, a, m, b, -1);
                if (m == 1) run_frame(d, b, 0, 8'h00, -1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
